// File: rtl/four_nand_tree_if.sv
// Operand/result bundle for four_nand_tree. The block is the slave; the producer is the master.
// The ev_cnt member exists only when FOUR_NAND_EVCNT_EN is defined.
interface four_nand_tree_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
`ifdef FOUR_NAND_EVCNT_EN
  logic [CNT_W-1:0] ev_cnt;

  modport master (output in_valid, a, b, c, d, input out_valid, e, f, g, ev_cnt);
  modport slave  (input in_valid, a, b, c, d, output out_valid, e, f, g, ev_cnt);
`else
  modport master (output in_valid, a, b, c, d, input out_valid, e, f, g);
  modport slave  (input in_valid, a, b, c, d, output out_valid, e, f, g);
`endif
endinterface

// File: rtl/four_nand_tree.sv
// Two-stage registered 4-input NAND tree over WIDTH independent lanes, with a valid pipe.
// Optional saturating all-ones event counter: define FOUR_NAND_EVCNT_EN.
module four_nand_lane (
  input  logic clk,
  input  logic rst,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
`ifdef FOUR_NAND_EVCNT_EN
  output logic o_g_nxt,
`endif
  output logic o_e,
  output logic o_f,
  output logic o_g
);
  logic r_s1_e, r_s1_f;
  logic r_e, r_f, r_g;
  logic w_g_nxt;

  // NAND of the two inverted first-level terms collapses to an OR.
  assign w_g_nxt = r_s1_e | r_s1_f;

  // Reset value is the NAND of all-zero operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_e <= 1'b1;
      r_s1_f <= 1'b1;
      r_e    <= 1'b1;
      r_f    <= 1'b1;
      r_g    <= 1'b1;
    end else begin
      r_s1_e <= ~(i_a & i_b);
      r_s1_f <= ~(i_c & i_d);
      r_e    <= r_s1_e;
      r_f    <= r_s1_f;
      r_g    <= w_g_nxt;
    end
  end

  assign o_e = r_e;
  assign o_f = r_f;
  assign o_g = r_g;
`ifdef FOUR_NAND_EVCNT_EN
  assign o_g_nxt = w_g_nxt;
`endif
endmodule

module four_nand_tree #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  four_nand_tree_if.slave bus
);
  localparam int STAGES = 2;

  logic [STAGES:1]  r_vld_pipe;
  logic [WIDTH-1:0] w_e, w_f, w_g;
`ifdef FOUR_NAND_EVCNT_EN
  logic [WIDTH-1:0] w_g_nxt;
  logic [CNT_W-1:0] r_ev_cnt;
  logic             w_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_vld_pipe <= '0;
    else     r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    four_nand_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_a     (bus.a[i]),
      .i_b     (bus.b[i]),
      .i_c     (bus.c[i]),
      .i_d     (bus.d[i]),
`ifdef FOUR_NAND_EVCNT_EN
      .o_g_nxt (w_g_nxt[i]),
`endif
      .o_e     (w_e[i]),
      .o_f     (w_f[i]),
      .o_g     (w_g[i])
    );
  end

  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.e         = w_e;
  assign bus.f         = w_f;
  assign bus.g         = w_g;

`ifdef FOUR_NAND_EVCNT_EN
  // Looks at the result about to land so the count includes the current output.
  assign w_hit = r_vld_pipe[STAGES-1] & ~(&w_g_nxt);

  always_ff @(posedge clk) begin
    if (rst)                           r_ev_cnt <= '0;
    else if (w_hit && !(&r_ev_cnt))    r_ev_cnt <= r_ev_cnt + 1'b1;
  end

  assign bus.ev_cnt = r_ev_cnt;
`endif
endmodule

// File: tb/tb_four_nand_tree.sv
// Randomized self-checking bench for four_nand_tree (WIDTH=4, CNT_W=2) against a cycle model.
// Counter checks are active when FOUR_NAND_EVCNT_EN is defined.
module tb_four_nand_tree;
  localparam int W  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  four_nand_tree_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  four_nand_tree #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: output after edge k is the spec function of operands sampled at edge k-1,
  // forced to the reset image if rst was high at edge k or k-1.
  typedef struct {
    logic         r;
    logic         v;
    logic [W-1:0] a, b, c, d;
  } rec_t;

  rec_t         prev = '{r: 1'b1, v: 1'b0, a: '0, b: '0, c: '0, d: '0};
  rec_t         cur;
  logic         exp_v;
  logic [W-1:0] exp_e, exp_f, exp_g;
  int           exp_cnt = 0;

  always @(posedge clk) begin
    cur = '{r: rst, v: bus.in_valid, a: bus.a, b: bus.b, c: bus.c, d: bus.d};
    if (cur.r || prev.r) begin
      exp_v = 1'b0;
      exp_e = '1;
      exp_f = '1;
      exp_g = '1;
    end else begin
      exp_v = prev.v;
      exp_e = ~(prev.a & prev.b);
      exp_f = ~(prev.c & prev.d);
      exp_g = ~(prev.a & prev.b & prev.c & prev.d);
    end
    if (cur.r) exp_cnt = 0;
    else if (exp_v && exp_g != '1 && exp_cnt < (1 << CW) - 1) exp_cnt++;
    prev = cur;
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    chk("e", 32'(bus.e), 32'(exp_e));
    chk("f", 32'(bus.f), 32'(exp_f));
    chk("g", 32'(bus.g), 32'(exp_g));
`ifdef FOUR_NAND_EVCNT_EN
    chk("ev_cnt", 32'(bus.ev_cnt), 32'(exp_cnt));
`endif
  end

  task automatic drive(input logic v, input logic [W-1:0] a, b, c, d);
    @(negedge clk);
    bus.in_valid = v;
    bus.a = a; bus.b = b; bus.c = c; bus.d = d;
  endtask

  // Hold operands for two edges, then compare against hand-computed results.
  task automatic lit(input string name, input logic [W-1:0] a, b, c, d,
                     input logic [W-1:0] ee, ef, eg);
    drive(1'b1, a, b, c, d);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk({name, ".e"}, 32'(bus.e), 32'(ee));
    chk({name, ".f"}, 32'(bus.f), 32'(ef));
    chk({name, ".g"}, 32'(bus.g), 32'(eg));
  endtask

  logic [5:0] vpat;
  logic [5:0] ov;
  logic [CW-1:0] cnt [0:9];

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;

    // Reset with random operands.
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      drive(1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    @(posedge clk); #2;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.g", 32'(bus.g), 32'hF);
    chk("rst.e", 32'(bus.e), 32'hF);
    @(negedge clk); rst = 1'b0;

    // Exhaustive {d,c,b,a} on lane 0, random upper lanes.
    for (int p = 0; p < 16; p++) begin
      logic [3:0] pv;
      pv = 4'(p);
      drive(1'b1, {3'($urandom), pv[0]}, {3'($urandom), pv[1]},
                  {3'($urandom), pv[2]}, {3'($urandom), pv[3]});
    end

    lit("p0011", 4'h1, 4'h1, 4'h0, 4'h0, 4'hE, 4'hF, 4'hF);
    lit("p1111", 4'h1, 4'h1, 4'h1, 4'h1, 4'hE, 4'hE, 4'hE);
    lit("alt",   4'hA, 4'hA, 4'hA, 4'hA, 4'h5, 4'h5, 4'h5);
    lit("cz",    4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF);

    // Valid pulse 1-0-1 shows up exactly two edges later.
    vpat = 6'b000101;
    for (int i = 0; i < 6; i++) begin
      drive(vpat[i], '0, '0, '0, '0);
      @(posedge clk); #2;
      ov[i] = bus.out_valid;
    end
    chk("vpipe1", 32'(ov[1]), 32'd1);
    chk("vpipe2", 32'(ov[2]), 32'd0);
    chk("vpipe3", 32'(ov[3]), 32'd1);
    chk("vpipe4", 32'(ov[4]), 32'd0);

    // Reset while a valid result is in stage 1.
    drive(1'b1, '1, '1, '1, '1);
    @(posedge clk);
    @(negedge clk); rst = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #2;
    chk("flight.rst", 32'(bus.out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    chk("flight.post", 32'(bus.out_valid), 32'd0);

`ifdef FOUR_NAND_EVCNT_EN
    // Saturation with CNT_W=2: 1,2,3,3,3 then frozen while invalid.
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(i < 5, '1, '1, '1, '1);
      rst = 1'b0;
      @(posedge clk); #2;
      cnt[i] = bus.ev_cnt;
    end
    chk("cnt0", 32'(cnt[0]), 32'd0);
    chk("cnt1", 32'(cnt[1]), 32'd1);
    chk("cnt2", 32'(cnt[2]), 32'd2);
    chk("cnt3", 32'(cnt[3]), 32'd3);
    chk("cnt5", 32'(cnt[5]), 32'd3);
    chk("cnt9", 32'(cnt[9]), 32'd3);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra, rb, rc, rd;
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
      // Bias toward all-ones lanes so g and the counter see zeros.
      if ($urandom_range(0, 3) == 0) begin ra = '1; rb = '1; rc = '1; rd = ~W'($urandom_range(0, 3)); end
      drive(1'($urandom), ra, rb, rc, rd);
      rst = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
